multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences the shared ALU, regfile, single unified
//  memory port and PC/IR/ALUOut registers across FETCH..WB states. Consumes op from IR; drives enables
//  and mux selects each cycle. ALU-function decode (funct3/funct7) stays in the separate ALU decoder via ALUOp.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter (wraps modulo 2**CNT_W)
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high
//  op           in   7      opcode from IR (valid from DECODE onward)
//  mem_ready    in   1      memory completes current access this cycle
//  mem_req      out  1      memory access in progress (FETCH, MEMREAD, MEMWRITE)
//  MemWrite     out  1      store strobe, held with mem_req in MEMWRITE
//  IRWrite      out  1      load IR (and OldPC) from memory data
//  PCUpdate     out  1      unconditional PC write
//  Branch       out  1      PC write qualified by ALU Zero (datapath ANDs)
//  RegWrite     out  1      regfile write enable
//  AdrSrc       out  1      0: address=PC, 1: address=Result
//  ALUSrcA      out  2      00 PC, 01 OldPC, 10 rs1 data
//  ALUSrcB      out  2      00 rs2 data, 01 ImmExt, 10 const 4
//  ResultSrc    out  2      00 ALUOut, 01 memory Data, 10 ALUResult
//  ImmSrc       out  3      000 I, 001 S, 010 B, 011 J; pure function of op
//  ALUOp        out  2      00 add, 01 sub(branch compare), 10 per funct
//  illegal      out  1      sticky: unsupported opcode decoded
//  instr_cnt    out  CNT_W  retired instructions
//  state_dbg    out  4      current state encoding
// BEHAVIOUR
//  States(enc): FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 ALUWB7 EXECI8 JAL9 BEQ10 JALRADR11 TRAP12.
//  Outputs Moore on state; IRWrite/PCUpdate in FETCH and DECODE->next additionally gated by mem_ready as below.
//  Unlisted outputs 0 (selects 00) in every state.
//  FETCH: mem_req, AdrSrc0, A=00, B=10, ALUOp00, ResultSrc10; IRWrite=PCUpdate=mem_ready; stay until mem_ready -> DECODE.
//  DECODE: A=01 B=01 ALUOp00 (ALUOut<=OldPC+imm). lw/sw->MEMADR; R->EXECR; I-ALU->EXECI; jal->JAL; jalr->JALRADR;
//    B-type->BEQ; any other op->TRAP.
//  MEMADR: A=10 B=01 ALUOp00; lw->MEMREAD, sw->MEMWRITE.
//  MEMREAD: mem_req, AdrSrc1, ResultSrc00; wait mem_ready -> MEMWB.  MEMWB: ResultSrc01, RegWrite -> FETCH.
//  MEMWRITE: mem_req, MemWrite, AdrSrc1, ResultSrc00; wait mem_ready -> FETCH.
//  EXECR: A=10 B=00 ALUOp10 -> ALUWB.  EXECI: A=10 B=01 ALUOp10 -> ALUWB.  ALUWB: ResultSrc00, RegWrite -> FETCH.
//  JALRADR: A=10 B=01 ALUOp00 (target into ALUOut; LSB clear is datapath's job) -> JAL.
//  JAL: A=01 B=10 ALUOp00 ResultSrc00 PCUpdate (PC<=ALUOut, ALUOut<=OldPC+4) -> ALUWB.
//  BEQ: A=10 B=00 ALUOp01 ResultSrc00 Branch -> FETCH.
//  TRAP: all enables/mem_req 0, illegal=1; remains until reset.
//  Latency (mem_ready tied 1): R/I 4, lw 5, sw 4, branch 3, jal 4, jalr 5 cycles.
//  instr_cnt +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; wraps all-ones->0.
//  ImmSrc combinational from op: lw/I-ALU/jalr 000, sw 001, B 010, jal 011, else 000.
//  Reset: while reset=1 all enables, mem_req forced 0 combinationally; next edge state=FETCH, illegal=0,
//    instr_cnt=0. Reset mid-MEMWRITE/MEMREAD aborts the access the same cycle; no partial retire counted.
//  mem_ready ignored in states without mem_req. mem_ready and reset together: reset wins.
// TESTING
//  1 reset 3 cycles, mem_ready=1 -> state_dbg=0, all enables 0 during reset, instr_cnt=0.
//  2 op=0110011, mem_ready=1 -> states 0,1,6,7,0; RegWrite only in ALUWB; instr_cnt=1.
//  3 op=0000011, mem_ready low 2 cycles in MEMREAD -> 0,1,2,3,3,3,4,0; mem_req,AdrSrc=1 held.
//  4 op=1100111 -> 0,1,11,9,7,0; PCUpdate in JAL only; ImmSrc=000; cnt+1.
//  5 op=1111111 -> TRAP, illegal=1 sticky 10 cycles, no enables; reset clears.
//  6 op=0100011, reset asserted 1st MEMWRITE cycle -> MemWrite/mem_req 0 that cycle, FETCH next, cnt unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, regfile, unified memory port and PC/IR/ALUOut
// registers. Control outputs are a Moore decode of the current state; only
// IRWrite/PCUpdate in FETCH also depend on mem_ready. Enables are forced low
// combinationally while reset is high.
module multicycle_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCUpdate,
   output logic             Branch,
   output logic             RegWrite,
   output logic             AdrSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic [2:0]       ImmSrc,
   output logic [1:0]       ALUOp,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [3:0]       state_dbg
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BTYPE = 7'b1100011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_JALRADR  = 4'd11,
      S_TRAP     = 4'd12
   } state_e;

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   logic is_load, is_store, is_rtype, is_itype, is_jal, is_jalr, is_btype;

   // Opcode class decode
   always_comb begin
      is_load  = (op == OP_LOAD);
      is_store = (op == OP_STORE);
      is_rtype = (op == OP_RTYPE);
      is_itype = (op == OP_ITYPE);
      is_jal   = (op == OP_JAL);
      is_jalr  = (op == OP_JALR);
      is_btype = (op == OP_BTYPE);
   end

   // Immediate format select, a pure function of the opcode
   always_comb begin
      ImmSrc = 3'b000;
      if (is_store)      ImmSrc = 3'b001;
      else if (is_btype) ImmSrc = 3'b010;
      else if (is_jal)   ImmSrc = 3'b011;
   end

   // Next-state logic; retire marks the cycle that completes an instruction
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_load || is_store) state_d = S_MEMADR;
            else if (is_rtype)       state_d = S_EXECR;
            else if (is_itype)       state_d = S_EXECI;
            else if (is_jal)         state_d = S_JAL;
            else if (is_jalr)        state_d = S_JALRADR;
            else if (is_btype)       state_d = S_BEQ;
            else                     state_d = S_TRAP;
         end
         S_MEMADR: begin
            state_d = is_load ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECR:   state_d = S_ALUWB;
         S_EXECI:   state_d = S_ALUWB;
         S_JALRADR: state_d = S_JAL;
         S_JAL:     state_d = S_ALUWB;
         S_ALUWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_BEQ: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // Sticky illegal flag and retired-instruction counter next values
   always_comb begin
      illegal_d = illegal_q | (state_d == S_TRAP);
      cnt_d     = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
   end

   // State, sticky flag and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   // Moore control decode; reset kills every enable in the same cycle
   always_comb begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ResultSrc = RES_ALUOUT;
      ALUOp     = ALUOP_ADD;
      unique case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            IRWrite   = mem_ready;
            PCUpdate  = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_FUNC;
         end
         S_EXECI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNC;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
         end
         S_JALRADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_JAL: begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            PCUpdate = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_SUB;
            Branch  = 1'b1;
         end
         S_TRAP: begin
         end
         default: begin
         end
      endcase
      if (reset) begin
         mem_req  = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         PCUpdate = 1'b0;
         Branch   = 1'b0;
         RegWrite = 1'b0;
      end
   end

   // Status outputs straight from the registers
   always_comb begin
      illegal   = illegal_q;
      instr_cnt = cnt_q;
      state_dbg = 4'(state_q);
   end

endmodule
